// File: rtl/seg7_scan_pkg.sv
// Shared constants and small helpers for the multiplexed 7-segment display path.
package seg7_scan_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;

  // All digit enables off (active-low)
  localparam logic [3:0] AN_OFF = 4'hF;

  // Digit slots in scan order
  typedef enum logic [1:0] {
    SLOT_EW_10 = 2'd0,
    SLOT_EW_1  = 2'd1,
    SLOT_SN_10 = 2'd2,
    SLOT_SN_1  = 2'd3
  } slot_e;

  // Active-low anode vector with a single 0 at the given slot
  function automatic logic [3:0] slot_anode(input slot_e slot);
    logic [3:0] an;
    case (slot)
      SLOT_EW_10: an = 4'b1110;
      SLOT_EW_1:  an = 4'b1101;
      SLOT_SN_10: an = 4'b1011;
      SLOT_SN_1:  an = 4'b0111;
      default:    an = AN_OFF;
    endcase
    return an;
  endfunction

  // Tens slots are the only candidates for leading-zero blanking
  function automatic logic is_tens_slot(input slot_e slot);
    return (slot == SLOT_EW_10) || (slot == SLOT_SN_10);
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// Digit inputs and display outputs of the scan block, grouped as one bundle.
interface seg7_scan_if;
  logic [3:0] bcd_ew_10;
  logic [3:0] bcd_ew_1;
  logic [3:0] bcd_sn_10;
  logic [3:0] bcd_sn_1;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       frame_done;

  // Source of digits / consumer of the display drive
  modport master (
    output bcd_ew_10, bcd_ew_1, bcd_sn_10, bcd_sn_1,
    input  an_n, seg_n, frame_done
  );

  // The scanner itself
  modport slave (
    input  bcd_ew_10, bcd_ew_1, bcd_sn_10, bcd_sn_1,
    output an_n, seg_n, frame_done
  );
endinterface

// File: rtl/seg7_decode.sv
// BCD to active-low 7-segment pattern; codes 10..15 render as a dash.
module seg7_decode
  import seg7_scan_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  // Pure lookup, dash for anything that is not a decimal digit
  always_comb begin
    seg_n = SEG_DASH;
    case (bcd)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit 7-segment driver. Digits are snapshotted once per
// frame, each slot starts with one blank cycle against ghosting, and tens digits
// equal to zero can be blanked. Outputs are registered and track the state the
// counters hold during the same cycle.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  seg7_scan_if.slave  disp
);

  localparam int             CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};

  logic [CW-1:0]    pre_cnt_r;
  logic [CW-1:0]    pre_cnt_nxt_s;
  slot_e            slot_r;
  slot_e            slot_nxt_s;
  logic             load_pend_r;
  logic [3:0][3:0]  shadow_r;
  logic [3:0][3:0]  shadow_nxt_s;
  logic             pre_wrap_s;
  logic             frame_end_s;
  logic             snap_s;

  logic [3:0]       digit_s;
  logic [6:0]       seg_dec_s;
  logic             lz_blank_s;
  logic [3:0]       an_nxt_s;
  logic [6:0]       seg_nxt_s;

  logic [3:0]       an_n_r;
  logic [6:0]       seg_n_r;
  logic             frame_done_r;

  // Next state of prescaler, slot and shadow registers
  always_comb begin
    pre_wrap_s   = (pre_cnt_r == CNT_MAX);
    frame_end_s  = pre_wrap_s && (slot_r == SLOT_SN_1);
    snap_s       = frame_end_s || load_pend_r;
    slot_nxt_s   = slot_r;
    if (pre_wrap_s) begin
      pre_cnt_nxt_s = CNT_ZERO;
      case (slot_r)
        SLOT_EW_10: slot_nxt_s = SLOT_EW_1;
        SLOT_EW_1:  slot_nxt_s = SLOT_SN_10;
        SLOT_SN_10: slot_nxt_s = SLOT_SN_1;
        SLOT_SN_1:  slot_nxt_s = SLOT_EW_10;
        default:    slot_nxt_s = SLOT_EW_10;
      endcase
    end else begin
      pre_cnt_nxt_s = pre_cnt_r + CW'(1);
      slot_nxt_s    = slot_r;
    end
    if (snap_s) begin
      shadow_nxt_s = {disp.bcd_sn_1, disp.bcd_sn_10, disp.bcd_ew_1, disp.bcd_ew_10};
    end else begin
      shadow_nxt_s = shadow_r;
    end
  end

  // Digit shown in the coming cycle
  assign digit_s = shadow_nxt_s[slot_nxt_s];

  seg7_decode u_decode (
    .bcd   (digit_s),
    .seg_n (seg_dec_s)
  );

  // Output pattern for the coming cycle: blank on the first cycle of a slot or a blanked leading zero
  always_comb begin
    lz_blank_s = BLANK_LZ && is_tens_slot(slot_nxt_s) && (digit_s == 4'd0);
    if ((pre_cnt_nxt_s == CNT_ZERO) || lz_blank_s) begin
      an_nxt_s  = AN_OFF;
      seg_nxt_s = SEG_BLANK;
    end else begin
      an_nxt_s  = slot_anode(slot_nxt_s);
      seg_nxt_s = seg_dec_s;
    end
  end

  // Scan state registers; a load is pending right after reset so the first frame is fresh
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt_r   <= CNT_ZERO;
      slot_r      <= SLOT_EW_10;
      load_pend_r <= 1'b1;
      shadow_r    <= {16{1'b0}};
    end else begin
      pre_cnt_r   <= pre_cnt_nxt_s;
      slot_r      <= slot_nxt_s;
      load_pend_r <= 1'b0;
      shadow_r    <= shadow_nxt_s;
    end
  end

  // Registered display drive and end-of-frame pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_n_r       <= AN_OFF;
      seg_n_r      <= SEG_BLANK;
      frame_done_r <= 1'b0;
    end else begin
      an_n_r       <= an_nxt_s;
      seg_n_r      <= seg_nxt_s;
      frame_done_r <= frame_end_s;
    end
  end

  assign disp.an_n       = an_n_r;
  assign disp.seg_n      = seg_n_r;
  assign disp.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: two instances (leading-zero blanking on/off)
// share the same digit inputs; a reference model predicts every output cycle.
module tb_seg7_scan;

  localparam int D     = 4;
  localparam int FRAME = 4 * D;
  localparam logic [6:0] SEG_TBL [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
    logic [3:0] an0;
    logic [6:0] seg0;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   k;
  int   in_d [4];
  int   shadow [4];
  exp_t sb_q [$];

  seg7_scan_if if_lz ();
  seg7_scan_if if_nolz ();

  seg7_scan #(.SCAN_DIV(D), .BLANK_LZ(1'b1)) u_dut_lz (
    .clk   (clk),
    .reset (rst_n),
    .disp  (if_lz)
  );

  seg7_scan #(.SCAN_DIV(D), .BLANK_LZ(1'b0)) u_dut_nolz (
    .clk   (clk),
    .reset (rst_n),
    .disp  (if_nolz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_inputs(input int a, input int b, input int c, input int d);
    in_d[0] = a; in_d[1] = b; in_d[2] = c; in_d[3] = d;
    if_lz.bcd_ew_10   = 4'(a); if_nolz.bcd_ew_10 = 4'(a);
    if_lz.bcd_ew_1    = 4'(b); if_nolz.bcd_ew_1  = 4'(b);
    if_lz.bcd_sn_10   = 4'(c); if_nolz.bcd_sn_10 = 4'(c);
    if_lz.bcd_sn_1    = 4'(d); if_nolz.bcd_sn_1  = 4'(d);
  endtask

  // Display rule for one cycle: blank first cycle of a slot, optional leading-zero blank
  task automatic ref_out(input int slot, input int pos, input int dig, input bit lz,
                         output logic [3:0] an, output logic [6:0] seg);
    if (pos == 0 || (lz && (slot == 0 || slot == 2) && dig == 0)) begin
      an  = 4'hF;
      seg = 7'h7F;
    end else begin
      an  = 4'hF & ~(4'(1) << slot);
      seg = (dig <= 9) ? SEG_TBL[dig] : 7'h3F;
    end
  endtask

  // Predict outputs after the next rising edge from elapsed time since reset, then wait a cycle
  task automatic tick();
    exp_t e;
    int   pos;
    int   slot;
    if (!rst_n) begin
      k      = 0;
      e.an   = 4'hF; e.seg  = 7'h7F; e.fd = 1'b0;
      e.an0  = 4'hF; e.seg0 = 7'h7F;
    end else begin
      k++;
      if (k == 1 || (k % FRAME) == 0) begin
        for (int i = 0; i < 4; i++) shadow[i] = in_d[i];
      end
      pos  = k % D;
      slot = (k / D) % 4;
      e.fd = ((k % FRAME) == 0);
      ref_out(slot, pos, shadow[slot], 1'b1, e.an, e.seg);
      ref_out(slot, pos, shadow[slot], 1'b0, e.an0, e.seg0);
    end
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: every cycle the DUTs present an output, compare against the queued prediction
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_empty: got no prediction expected one at %0t", $time);
    end else begin
      e = sb_q.pop_front();
      check("an_n_lz",       {4'h0, if_lz.an_n},        {4'h0, e.an});
      check("seg_n_lz",      {1'b0, if_lz.seg_n},       {1'b0, e.seg});
      check("frame_done_lz", {7'h0, if_lz.frame_done},  {7'h0, e.fd});
      check("an_n_nolz",     {4'h0, if_nolz.an_n},      {4'h0, e.an0});
      check("seg_n_nolz",    {1'b0, if_nolz.seg_n},     {1'b0, e.seg0});
      check("frame_done_nolz", {7'h0, if_nolz.frame_done}, {7'h0, e.fd});
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    k     = 0;
    for (int i = 0; i < 4; i++) shadow[i] = 0;
    rst_n = 1'b0;
    set_inputs(6, 0, 2, 9);

    // Reset held for three cycles
    run(3);

    // Normal frames: 6,0 / 2,9
    rst_n = 1'b1;
    run(2 * FRAME);

    // Leading zero on EW, then both EW digits zero
    set_inputs(0, 5, 2, 9);
    run(2 * FRAME);
    set_inputs(0, 0, 2, 9);
    run(2 * FRAME);

    // Input change during slot 1 must not reach slot 3 before the frame ends
    set_inputs(6, 0, 2, 9);
    run(FRAME);
    for (int n = 0; n < 2 * FRAME && (k % FRAME) != D + 1; n++) tick();
    set_inputs(6, 0, 2, 8);
    run(2 * FRAME);

    // Invalid code shows a dash
    set_inputs(6, 0, 2, 12);
    run(2 * FRAME);

    // Asynchronous reset during slot 2
    set_inputs(4, 7, 1, 3);
    run(FRAME);
    for (int n = 0; n < 2 * FRAME && (k % FRAME) != 2 * D + 1; n++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_an_n_lz",   {4'h0, if_lz.an_n},   8'h0F);
    check("async_seg_n_lz",  {1'b0, if_lz.seg_n},  8'h7F);
    check("async_an_n_nolz", {4'h0, if_nolz.an_n}, 8'h0F);
    run(2);
    set_inputs(3, 1, 0, 6);
    rst_n = 1'b1;
    run(2 * FRAME);

    // Randomized digits and occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        in_d[$urandom_range(0, 3)] = int'($urandom_range(0, 15));
        set_inputs(in_d[0], in_d[1], in_d[2], in_d[3]);
      end
      rst_n = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst_n = 1'b1;
    run(FRAME);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
